// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing, coordinate type and sync-window helpers.
package vga_pkg;
   typedef logic [9:0] coord_t;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
   function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
      return (v >= lo) && (v <= hi);
   endfunction
endpackage

// File: rtl/vga_if.sv
// vga_if: raster timing bundle from the timing generator to the video path and DAC.
// Carries frame_cnt only when VGA_FRAME_CNT_EN is defined.
interface vga_if;
   import vga_pkg::*;
   coord_t x;
   coord_t y;
   logic hsync_n;
   logic vsync_n;
   logic blank_n;
   logic vga_clk;
   logic pix_en;
   logic frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   modport master (output x, y, hsync_n, vsync_n, blank_n, vga_clk, pix_en, frame_start, frame_cnt);
   modport slave  (input  x, y, hsync_n, vsync_n, blank_n, vga_clk, pix_en, frame_start, frame_cnt);
`else
   modport master (output x, y, hsync_n, vsync_n, blank_n, vga_clk, pix_en, frame_start);
   modport slave  (input  x, y, hsync_n, vsync_n, blank_n, vga_clk, pix_en, frame_start);
`endif
endinterface

// File: rtl/pix_clk_div.sv
// pix_clk_div: divides clk into a one-clk pixel strobe and a ~50% duty pixel clock.
module pix_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_en,
   output logic vga_clk
);
   localparam int W = $clog2(CLK_DIV);
   logic [W-1:0] div_cnt;
   assign pix_en  = div_cnt == W'(CLK_DIV - 1);
   // Second half of the period is high, so the rising edge lands mid-pixel.
   assign vga_clk = div_cnt >= W'(CLK_DIV / 2);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) div_cnt <= '0;
      else        div_cnt <= pix_en ? '0 : div_cnt + W'(1);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with zero-skew registered sync/blank outputs.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP
) (
   input logic   clk,
   input logic   rst_n,
   vga_if.master vo
);
   import vga_pkg::*;
   localparam coord_t X_LAST = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam coord_t Y_LAST = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam coord_t X_VIS  = coord_t'(H_ACTIVE);
   localparam coord_t Y_VIS  = coord_t'(V_ACTIVE);
   localparam coord_t HS_LO  = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_HI  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam coord_t VS_LO  = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_HI  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
   logic   pix_en;
   logic   vga_clk;
   logic   sof;
   coord_t x_nx;
   coord_t y_nx;
   pix_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix_en (pix_en),
      .vga_clk(vga_clk)
   );
   assign vo.pix_en  = pix_en;
   assign vo.vga_clk = vga_clk;
   always_comb begin
      x_nx = (vo.x == X_LAST) ? '0 : vo.x + coord_t'(1);
      y_nx = (vo.x != X_LAST) ? vo.y : (vo.y == Y_LAST) ? '0 : vo.y + coord_t'(1);
      sof  = (x_nx == '0) && (y_nx == '0);
   end
   // Reset parks at the last blanking pixel so the first pixel strobe opens a full frame.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vo.x           <= X_LAST;
         vo.y           <= Y_LAST;
         vo.hsync_n     <= 1'b1;
         vo.vsync_n     <= 1'b1;
         vo.blank_n     <= 1'b0;
         vo.frame_start <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
         vo.frame_cnt   <= '0;
`endif
      end else if (pix_en) begin
         vo.x           <= x_nx;
         vo.y           <= y_nx;
         vo.hsync_n     <= !in_range(x_nx, HS_LO, HS_HI);
         vo.vsync_n     <= !in_range(y_nx, VS_LO, VS_HI);
         vo.blank_n     <= (x_nx < X_VIS) && (y_nx < Y_VIS);
         vo.frame_start <= sof;
`ifdef VGA_FRAME_CNT_EN
         if (sof) vo.frame_cnt <= vo.frame_cnt + 16'd1;
`endif
      end else begin
         vo.frame_start <= 1'b0;
      end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors for vga_timing_gen with full horizontal timing
// and a shortened vertical geometry (13 lines, vsync on lines 8..9) to keep frames short.
module tb_vga_timing_gen;
   localparam int VA = 6, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int n_vec = 0;
   int n_err = 0;
   int edge_n = 0;
   vga_if vo();
   vga_timing_gen #(
      .CLK_DIV(2), .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .vo   (vo)
   );
   always #5 clk = ~clk;
   typedef struct {
      int p;
      int x;
      int y;
      bit hs;
      bit vs;
      bit bl;
      bit fs;
   } vec_t;
   vec_t tv[19];
   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   task automatic chk_state(string nm, int x, int y, bit hs, bit vs, bit bl, bit fs);
      chk({nm, ".x"}, int'(vo.x), x);
      chk({nm, ".y"}, int'(vo.y), y);
      chk({nm, ".hsync_n"}, int'(vo.hsync_n), int'(hs));
      chk({nm, ".vsync_n"}, int'(vo.vsync_n), int'(vs));
      chk({nm, ".blank_n"}, int'(vo.blank_n), int'(bl));
      chk({nm, ".frame_start"}, int'(vo.frame_start), int'(fs));
   endtask
   task automatic tick(int n);
      repeat (n) @(negedge clk);
      edge_n += n;
   endtask
   task automatic release_seq(string nm);
      rst_n  = 1'b1;
      edge_n = 0;
      tick(1);
      chk_state({nm, ".e1"}, 799, VT - 1, 1, 1, 0, 0);
      chk({nm, ".e1.pix_en"}, int'(vo.pix_en), 1);
      chk({nm, ".e1.vga_clk"}, int'(vo.vga_clk), 1);
      tick(1);
      chk_state({nm, ".e2"}, 0, 0, 1, 1, 1, 1);
      chk({nm, ".e2.pix_en"}, int'(vo.pix_en), 0);
      chk({nm, ".e2.vga_clk"}, int'(vo.vga_clk), 0);
`ifdef VGA_FRAME_CNT_EN
      chk({nm, ".e2.frame_cnt"}, int'(vo.frame_cnt), 1);
`endif
      tick(1);
      chk_state({nm, ".e3"}, 0, 0, 1, 1, 1, 0);
      chk({nm, ".e3.pix_en"}, int'(vo.pix_en), 1);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int period, vs_lo, hs_lo, x_bad, prev_x, waited;
      bit prev_pe, found;
      tv = '{
         '{1,     1,   0, 1, 1, 1, 0},
         '{639,   639, 0, 1, 1, 1, 0},
         '{640,   640, 0, 1, 1, 0, 0},
         '{655,   655, 0, 1, 1, 0, 0},
         '{656,   656, 0, 0, 1, 0, 0},
         '{751,   751, 0, 0, 1, 0, 0},
         '{752,   752, 0, 1, 1, 0, 0},
         '{799,   799, 0, 1, 1, 0, 0},
         '{800,   0,   1, 1, 1, 1, 0},
         '{4639,  639, 5, 1, 1, 1, 0},
         '{4800,  0,   6, 1, 1, 0, 0},
         '{6399,  799, 7, 1, 1, 0, 0},
         '{6400,  0,   8, 1, 0, 0, 0},
         '{7056,  656, 8, 0, 0, 0, 0},
         '{7999,  799, 9, 1, 0, 0, 0},
         '{8000,  0,  10, 1, 1, 0, 0},
         '{10399, 799, 12, 1, 1, 0, 0},
         '{10400, 0,   0, 1, 1, 1, 1},
         '{10401, 1,   0, 1, 1, 1, 0}
      };
      #1 rst_n = 1'b0;
      #2;
      chk_state("rst_async", 799, VT - 1, 1, 1, 0, 0);
      chk("rst_async.pix_en", int'(vo.pix_en), 0);
      repeat (3) @(negedge clk);
      chk_state("rst_hold", 799, VT - 1, 1, 1, 0, 0);
      release_seq("start");
      // Pixel p is presented after release edge 2+2p.
      for (int i = 0; i < $size(tv); i++) begin
         tick(2 + 2 * tv[i].p - edge_n);
         chk_state($sformatf("vec%0d_p%0d", i, tv[i].p), tv[i].x, tv[i].y,
                   tv[i].hs, tv[i].vs, tv[i].bl, tv[i].fs);
         chk($sformatf("vec%0d.pix_en", i), int'(vo.pix_en), 0);
`ifdef VGA_FRAME_CNT_EN
         if (tv[i].fs) chk($sformatf("vec%0d.frame_cnt", i), int'(vo.frame_cnt), 2);
`endif
      end
      vs_lo = 0; hs_lo = 0; x_bad = 0; found = 0;
      prev_x = int'(vo.x); prev_pe = vo.pix_en;
      for (int n = 0; n < 25000 && !found; n++) begin
         tick(1);
         if (int'(vo.x) != prev_x && !prev_pe) x_bad++;
         if (!vo.vsync_n) vs_lo++;
         if (!vo.hsync_n && vo.y == 10'd1) hs_lo++;
         prev_x = int'(vo.x); prev_pe = vo.pix_en;
         found = vo.frame_start;
      end
      period = edge_n - (2 + 2 * 10400);
      chk("frame2.found", int'(found), 1);
      chk("frame.period_clks", period, 20800);
      chk("frame.vsync_low_clks", vs_lo, 3200);
      chk("line1.hsync_low_clks", hs_lo, 192);
      chk("x_change_off_pix_en", x_bad, 0);
      chk_state("frame2.start", 0, 0, 1, 1, 1, 1);
`ifdef VGA_FRAME_CNT_EN
      chk("frame2.frame_cnt", int'(vo.frame_cnt), 3);
`endif
      found = 0; waited = 0;
      while (!found && waited < 20000) begin
         tick(1);
         waited++;
         found = (vo.x == 10'd700) && (vo.y == 10'd8);
      end
      chk("midreset.reached", int'(found), 1);
      chk("midreset.pre_vsync_n", int'(vo.vsync_n), 0);
      #2 rst_n = 1'b0;
      #1;
      chk_state("midreset.async", 799, VT - 1, 1, 1, 0, 0);
      repeat (2) @(negedge clk);
      chk_state("midreset.hold", 799, VT - 1, 1, 1, 0, 0);
      release_seq("restart");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
